// File: rtl/mux21_pkg.sv
// Shared constants for the 2:1 byte mux feeder: channel select encoding and
// default datapath width / burst limit.
package mux21_pkg;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_BURST = 4;

endpackage

// File: rtl/mux21_2bit.sv
// Plain 2:1 mux over a WIDTH-bit word; s=0 passes a, s=1 passes b.
module mux21_2bit
  import mux21_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = (s == CH_B) ? b : a;

endmodule

// File: rtl/rr_arb2.sv
// Burst-limited round-robin arbiter for two requesters. Tracks the current owner
// and how many beats it has taken in its tenure; the other side wins once BURST is hit.
module rr_arb2
  import mux21_pkg::*;
#(
  parameter int BURST = DEFAULT_BURST
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  input  logic load,
  output logic grant,
  output logic grant_vld,
  output logic sel
);

  localparam int CW = $clog2(BURST + 1);

  logic          owner;
  logic [CW-1:0] cnt;
  logic          sel_q;
  logic          own_valid;
  logic          oth_valid;

  // The owner keeps the grant until its burst is used up, and only then if the
  // other side is actually waiting.
  always_comb begin
    own_valid = (owner == CH_A) ? a_valid : b_valid;
    oth_valid = (owner == CH_A) ? b_valid : a_valid;
    grant     = owner;
    grant_vld = 1'b0;
    if (own_valid && ((cnt < CW'(BURST)) || !oth_valid)) begin
      grant_vld = 1'b1;
    end else if (oth_valid) begin
      grant     = ~owner;
      grant_vld = 1'b1;
    end
    sel = load ? grant : sel_q;
  end

  // sel_q freezes the mux select across an output stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= CH_A;
      cnt   <= '0;
      sel_q <= CH_A;
    end else begin
      sel_q <= sel;
      if (load && grant_vld) begin
        if (grant == owner) begin
          if (cnt != CW'(BURST)) begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          owner <= grant;
          cnt   <= CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mux21_rr_feeder.sv
// Arbitrates two valid/ready byte channels onto mux21_2bit and registers the
// selected byte into a one-deep output slot with its own valid/ready handshake.
module mux21_rr_feeder
  import mux21_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BURST = DEFAULT_BURST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             sel,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  output logic             y_src,
  input  logic             y_ready
);

  logic             load;
  logic             grant;
  logic             grant_vld;
  logic [WIDTH-1:0] mux_y;

  assign load = ~y_valid | y_ready;

  rr_arb2 #(
    .BURST(BURST)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .b_valid  (b_valid),
    .load     (load),
    .grant    (grant),
    .grant_vld(grant_vld),
    .sel      (sel)
  );

  mux21_2bit #(
    .WIDTH(WIDTH)
  ) u_mux (
    .a(a_data),
    .b(b_data),
    .s(sel),
    .y(mux_y)
  );

  assign a_ready = load & grant_vld & (grant == CH_A) & a_valid;
  assign b_ready = load & grant_vld & (grant == CH_B) & b_valid;

  // Output slot: refill whenever it is free or draining, otherwise hold the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_data  <= '0;
      y_src   <= CH_A;
      y_valid <= 1'b0;
    end else if (load) begin
      if (grant_vld) begin
        y_data  <= mux_y;
        y_src   <= grant;
        y_valid <= 1'b1;
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux21_rr_feeder.sv
// Self-checking bench for mux21_rr_feeder (BURST=4): a scoreboard tracks every
// accepted beat, and per-scenario tasks check arbitration, stalls and reset.
module tb_mux21_rr_feeder;

  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] a_data = '0;
  logic             a_valid = 1'b0;
  logic             a_ready;
  logic [WIDTH-1:0] b_data = '0;
  logic             b_valid = 1'b0;
  logic             b_ready;
  logic             sel;
  logic [WIDTH-1:0] y_data;
  logic             y_valid;
  logic             y_src;
  logic             y_ready = 1'b0;

  int total = 0;
  int bad = 0;

  logic [WIDTH:0] exp_q[$];

  mux21_rr_feeder #(
    .WIDTH(WIDTH),
    .BURST(BURST)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_data (a_data),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .b_data (b_data),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .sel    (sel),
    .y_data (y_data),
    .y_valid(y_valid),
    .y_src  (y_src),
    .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  // Scoreboard: consumed output beats are checked against accepted input beats in order.
  always @(negedge clk) begin
    logic [WIDTH:0] exp;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (y_valid && y_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL sb_extra got src=%0d data=%h want none", y_src, y_data);
        end else begin
          exp = exp_q.pop_front();
          if ({y_src, y_data} !== exp) begin
            bad++;
            $display("[TB] FAIL sb_beat got src=%0d data=%h want src=%0d data=%h",
                     y_src, y_data, exp[WIDTH], exp[WIDTH-1:0]);
          end
        end
      end
      if (a_valid && a_ready) exp_q.push_back({1'b0, a_data});
      if (b_valid && b_ready) exp_q.push_back({1'b1, b_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    a_data  = 8'h55;
    b_data  = 8'hAA;
    a_valid = 1'b1;
    b_valid = 1'b1;
    y_ready = 1'b1;
    step();
    total++;
    if (y_valid !== 1'b0 || y_data !== 8'h00 || y_src !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state got v=%b d=%h s=%b want v=0 d=00 s=0", y_valid, y_data, y_src);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0 || sel !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_first_grant got ar=%b br=%b sel=%b want ar=1 br=0 sel=0", a_ready, b_ready, sel);
    end
    step();
    total++;
    if (y_valid !== 1'b1 || y_src !== 1'b0 || y_data !== 8'h55) begin
      bad++;
      $display("[TB] FAIL reset_first_beat got v=%b s=%b d=%h want v=1 s=0 d=55", y_valid, y_src, y_data);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
    total++;
    if (y_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_drain got v=%b want v=0", y_valid);
    end
  endtask

  task automatic test_a_stream();
    b_valid = 1'b0;
    y_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      a_data  = 8'(i);
      a_valid = 1'b1;
      @(negedge clk);
      total++;
      if (a_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL a_stream_ready beat=%0d got=%b want=1", i, a_ready);
      end
      step();
      total++;
      if (y_valid !== 1'b1 || y_src !== 1'b0 || y_data !== 8'(i)) begin
        bad++;
        $display("[TB] FAIL a_stream_y beat=%0d got v=%b s=%b d=%h want v=1 s=0 d=%h",
                 i, y_valid, y_src, y_data, 8'(i));
      end
    end
    a_valid = 1'b0;
    step();
    total++;
    if (y_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL a_stream_drain got v=%b want v=0", y_valid);
    end
  endtask

  task automatic test_round_robin();
    logic exp_ch;
    do_reset();
    a_data  = 8'h10;
    b_data  = 8'h80;
    a_valid = 1'b1;
    b_valid = 1'b1;
    y_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_ch = ((i / BURST) % 2) == 1;
      @(negedge clk);
      total++;
      if (sel !== exp_ch || (exp_ch ? b_ready : a_ready) !== 1'b1) begin
        bad++;
        $display("[TB] FAIL rr_grant cycle=%0d got sel=%b ar=%b br=%b want sel=%b",
                 i, sel, a_ready, b_ready, exp_ch);
      end
      step();
      total++;
      if (y_valid !== 1'b1 || y_src !== exp_ch) begin
        bad++;
        $display("[TB] FAIL rr_src cycle=%0d got v=%b s=%b want v=1 s=%b", i, y_valid, y_src, exp_ch);
      end
      if (exp_ch) b_data = b_data + 8'd1;
      else a_data = a_data + 8'd1;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_back_to_back_stall();
    b_valid = 1'b0;
    a_valid = 1'b1;
    a_data  = 8'h20;
    y_ready = 1'b1;
    step();
    a_data  = 8'h21;
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0 || y_valid !== 1'b1 || y_data !== 8'h20) begin
        bad++;
        $display("[TB] FAIL stall_hold cycle=%0d got ar=%b br=%b v=%b d=%h want ar=0 br=0 v=1 d=20",
                 i, a_ready, b_ready, y_valid, y_data);
      end
      step();
    end
    y_ready = 1'b1;
    @(negedge clk);
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stall_resume_ready got=%b want=1", a_ready);
    end
    step();
    total++;
    if (y_data !== 8'h21) begin
      bad++;
      $display("[TB] FAIL stall_resume_y got d=%h want d=21", y_data);
    end
    a_data = 8'h22;
    step();
    total++;
    if (y_data !== 8'h22) begin
      bad++;
      $display("[TB] FAIL stall_next_y got d=%h want d=22", y_data);
    end
    a_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_saturate_switch();
    do_reset();
    y_ready = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_data = 8'h30 + 8'(i);
      @(negedge clk);
      total++;
      if (a_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL sat_a_ready beat=%0d got=%b want=1", i, a_ready);
      end
      step();
    end
    a_data  = 8'h36;
    b_data  = 8'hB5;
    b_valid = 1'b1;
    @(negedge clk);
    total++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0 || sel !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sat_switch got ar=%b br=%b sel=%b want ar=0 br=1 sel=1", a_ready, b_ready, sel);
    end
    step();
    total++;
    if (y_src !== 1'b1 || y_data !== 8'hB5) begin
      bad++;
      $display("[TB] FAIL sat_switch_y got s=%b d=%h want s=1 d=b5", y_src, y_data);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_async_reset();
    y_ready = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b1;
    b_data  = 8'h60;
    step();
    b_data = 8'h61;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (y_valid !== 1'b0 || y_data !== 8'h00) begin
      bad++;
      $display("[TB] FAIL async_reset got v=%b d=%h want v=0 d=00", y_valid, y_data);
    end
    a_data  = 8'h70;
    b_data  = 8'h71;
    a_valid = 1'b1;
    b_valid = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0 || sel !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset_grant got ar=%b br=%b sel=%b want ar=1 br=0 sel=0", a_ready, b_ready, sel);
    end
    step();
    total++;
    if (y_src !== 1'b0 || y_data !== 8'h70) begin
      bad++;
      $display("[TB] FAIL async_reset_y got s=%b d=%h want s=0 d=70", y_src, y_data);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_a_stream();
    test_round_robin();
    test_back_to_back_stall();
    test_saturate_switch();
    test_async_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_leftover got %0d beats pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
